// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
package hazard_ctrl_pkg;

    // MIPS register index width
    localparam int REG_W        = 5;

    // Default counter width and memory-wait timeout threshold
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_MAX_WAIT = 64;

    // Controller state: running, or frozen waiting on data memory
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline status inputs and register-control outputs of hazard_ctrl.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath side: supplies pipeline status, receives enables/flushes
    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, timeout, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step up until MAX and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: load-use
// stalls, branch/jump redirects, data-memory freeze with sticky timeout.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e            state_q;
    state_e            state_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [WAIT_W-1:0] wait_cnt;

    logic freeze;
    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic wait_clr;
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
    logic exmem_en_c, memwb_en_c;

    assign freeze   = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.ex_memread && (bus.ex_rd != '0) &&
                      ((bus.ex_rd == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    // State transition plus Mealy enable/flush decode in priority order
    always_comb begin
        state_d      = state_q;
        wait_clr     = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b1;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;

        if (state_q == RUN) begin
            if (freeze) state_d = MEM_WAIT;
        end else begin
            if (!freeze) begin
                state_d  = RUN;
                wait_clr = 1'b1;
            end
        end

        if (freeze) begin
            // Hold every stage; ID/EX contents stay valid for re-evaluation
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
            stall_inc  = 1'b1;
        end else if (bus.ex_branch_taken) begin
            // Squash both younger instructions, including any load-use/jump in ID
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            // Hold PC and ID, insert a bubble into EX; a jump in ID waits a cycle
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
            stall_inc    = 1'b1;
        end else if (bus.id_jump) begin
            ifid_flush_c = 1'b1;
            flush_inc    = 1'b1;
        end

        if (reset) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            ifid_flush_c = 1'b0;
            idex_en_c    = 1'b0;
            idex_flush_c = 1'b0;
            exmem_en_c   = 1'b0;
            memwb_en_c   = 1'b0;
        end
    end

    // Timeout latches once the current freeze brings the wait count to MAX_WAIT
    always_comb begin
        timeout_d = timeout_q | (freeze && (wait_cnt >= (WAIT_MAX - 1'b1)));
    end

    // State and sticky timeout registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (1'b0),
        .inc_i (flush_inc),
        .cnt_o (bus.flush_cnt)
    );

    // Consecutive freeze cycles; 0 in RUN, first freeze cycle brings it to 1
    sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (wait_clr),
        .inc_i (freeze),
        .cnt_o (wait_cnt)
    );

    assign bus.pc_en      = pc_en_c;
    assign bus.ifid_en    = ifid_en_c;
    assign bus.ifid_flush = ifid_flush_c;
    assign bus.idex_en    = idex_en_c;
    assign bus.idex_flush = idex_flush_c;
    assign bus.exmem_en   = exmem_en_c;
    assign bus.memwb_en   = memwb_en_c;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

    localparam int TB_CNT_W    = 4;
    localparam int TB_MAX_WAIT = 4;

    // Control word order: pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, memwb
    localparam logic [6:0] C_RUN = 7'b1101011;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [6:0] C_BR  = 7'b1111111;
    localparam logic [6:0] C_LU  = 7'b0001111;
    localparam logic [6:0] C_JMP = 7'b1111011;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] ctl;
        int         stall;
        int         flush;
        logic       to;
    } vec_t;

    typedef struct {
        logic [6:0] ctl;
        int         stall;
        int         flush;
        logic       to;
    } exp_t;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t tbl[$];

    hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hif ();

    hazard_ctrl #(.CNT_W(TB_CNT_W), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic jump,
                                input logic memread, input logic [4:0] rd,
                                input logic br, input logic req, input logic rdy,
                                input logic [6:0] ctl, input int stall,
                                input int flush, input logic to);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump;
        v.memread = memread; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy;
        v.ctl = ctl; v.stall = stall; v.flush = flush; v.to = to;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
                hif.idex_flush, hif.exmem_en, hif.memwb_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hif.id_rs           = v.rs;
        hif.id_rt           = v.rt;
        hif.id_uses_rt      = v.uses_rt;
        hif.id_jump         = v.jump;
        hif.ex_memread      = v.memread;
        hif.ex_rd           = v.rd;
        hif.ex_branch_taken = v.br;
        hif.mem_req         = v.req;
        hif.mem_ready       = v.rdy;
    endtask

    // Drive one cycle of inputs, check Mealy outputs before the edge and
    // registered outputs just after it.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        drive(v);
        sb.push_back('{v.ctl, v.stall, v.flush, v.to});
        #2;
        e = sb.pop_front();
        chk({name, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
        @(posedge clock);
        #1;
        chk({name, ".stall"},   32'(hif.stall_cnt), 32'(e.stall));
        chk({name, ".flush"},   32'(hif.flush_cnt), 32'(e.flush));
        chk({name, ".timeout"}, 32'(hif.timeout),   32'(e.to));
    endtask

    // Raise reset between edges and verify the asynchronous clear before the next edge
    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #2;
        chk({name, ".ctl"},     32'(ctl_now()),     32'(C_FRZ));
        chk({name, ".stall"},   32'(hif.stall_cnt), 32'd0);
        chk({name, ".flush"},   32'(hif.flush_cnt), 32'd0);
        chk({name, ".timeout"}, 32'(hif.timeout),   32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        // Load-use pattern present during reset: controls must still be 0
        drive(mk(5, 0, 0, 1, 1, 5, 1, 0, 0, C_FRZ, 0, 0, 0));
        #3;
        chk("rst.ctl",     32'(ctl_now()),     32'(C_FRZ));
        chk("rst.stall",   32'(hif.stall_cnt), 32'd0);
        chk("rst.flush",   32'(hif.flush_cnt), 32'd0);
        chk("rst.timeout", 32'(hif.timeout),   32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        //             rs rt ur jp mr rd br rq rdy ctl    stl fl to
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0)); // idle
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN, 0, 0, 0)); // rd=$0
        tbl.push_back(mk(3, 7, 0, 0, 1, 7, 0, 0, 0, C_RUN, 0, 0, 0)); // rt unused
        tbl.push_back(mk(3, 7, 1, 0, 1, 7, 0, 0, 0, C_LU,  1, 0, 0)); // rt match
        tbl.push_back(mk(5, 0, 0, 0, 1, 5, 0, 0, 0, C_LU,  2, 0, 0)); // rs match
        tbl.push_back(mk(5, 0, 0, 0, 0, 5, 0, 0, 0, C_RUN, 2, 0, 0)); // bubble in EX
        tbl.push_back(mk(5, 0, 0, 0, 1, 5, 1, 0, 0, C_BR,  2, 1, 0)); // branch beats LU
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 0, C_JMP, 2, 2, 0)); // jump
        tbl.push_back(mk(9, 0, 0, 1, 1, 9, 0, 0, 0, C_LU,  3, 2, 0)); // jump deferred
        tbl.push_back(mk(9, 0, 0, 1, 0, 9, 0, 0, 0, C_JMP, 3, 3, 0)); // jump applied
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 4, 3, 0)); // freeze 1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 5, 3, 0)); // freeze 2
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 6, 3, 0)); // freeze 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR,  6, 4, 0)); // release, branch
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 6, 4, 0)); // req+ready
        tbl.push_back(mk(4, 0, 0, 0, 1, 4, 0, 1, 0, C_FRZ, 7, 4, 0)); // freeze over LU
        tbl.push_back(mk(4, 0, 0, 0, 1, 4, 0, 1, 1, C_LU,  8, 4, 0)); // LU after release
        tbl.push_back(mk(2, 0, 0, 1, 1, 2, 1, 0, 0, C_BR,  8, 5, 0)); // branch+jump+LU
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 8, 5, 0)); // idle

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Timeout: six wait cycles, timeout visible after the fourth
        pulse_reset("rst2");
        for (int k = 1; k <= 6; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, k, 0, logic'(k >= 4)),
                  $sformatf("to_wait%0d", k));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 6, 0, 1), "to_release");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 7, 0, 1), "to_rewait1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 8, 0, 1), "to_rewait2");
        // Reset lands mid-MEM_WAIT with the freeze still driven
        pulse_reset("rst_midwait");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0), "post_rst_idle");
        // Wait counter must restart from zero after that reset
        for (int k = 1; k <= 4; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, k, 0, logic'(k >= 4)),
                  $sformatf("rewait%0d", k));

        // Counter saturation at 2^CNT_W-1
        pulse_reset("rst3");
        for (int k = 1; k <= 17; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, (k > 15) ? 15 : k, 0,
                     logic'(k >= 4)), $sformatf("sat_stall%0d", k));
        for (int k = 1; k <= 17; k++)
            apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, C_JMP, 15, (k > 15) ? 15 : k, 1),
                  $sformatf("sat_flush%0d", k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Drives the enable and flush (bubble) inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, redirects on taken branch/jump, and freezes the pipeline while data memory is not ready, with a wait timeout.
- Keeps saturating stall/flush counters for debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)
MAX_WAIT, 64, consecutive MEM_WAIT cycles before timeout is flagged (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
id_jump  input  1  ID instruction is a jump (redirect resolved in ID)
ex_memread  input  1  MemRead of instruction in EX (ID/EX output)
ex_rd  input  5  destination register of instruction in EX (ID/EX output)
ex_branch_taken  input  1  branch in EX resolved taken
mem_req  input  1  MEM stage issuing a data-memory access this cycle
mem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC load enable
ifid_en  output  1  IF/ID enable
ifid_flush  output  1  IF/ID load of NOP
idex_en  output  1  ID/EX enable
idex_flush  output  1  ID/EX load of bubble (all control bits 0)
exmem_en  output  1  EX/MEM enable
memwb_en  output  1  MEM/WB enable
timeout  output  1  sticky: memory wait exceeded MAX_WAIT
stall_cnt  output  CNT_W  stall cycles since reset
flush_cnt  output  CNT_W  redirect events since reset

Behaviour:
- Async reset:
  - State RUN; wait counter, stall_cnt, flush_cnt and timeout cleared to 0.
  - While reset is high, all *_en = 0 and all *_flush = 0.
- Control outputs are combinational (Mealy) from state and inputs; they act in the same cycle. Counters and state are registered.
- Signals:
  - freeze = mem_req & ~mem_ready.
  - load_use = ex_memread & ex_rd != 0 & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- Priority, highest first:
  1. freeze: all five enables = 0, flushes = 0. Branch, jump and load-use are ignored and re-evaluated once the freeze ends; EX and ID contents are held, so the inputs are still valid then.
  2. ex_branch_taken: all enables = 1, ifid_flush = 1, idex_flush = 1; flush_cnt += 1. A simultaneous load_use or id_jump is ignored because that ID instruction is squashed.
  3. load_use: pc_en = 0, ifid_en = 0, idex_en = 1 with idex_flush = 1, exmem_en = memwb_en = 1; stall_cnt += 1. A simultaneous id_jump is deferred to the next cycle, since the jump stays in ID.
  4. id_jump: all enables = 1, ifid_flush = 1; flush_cnt += 1.
  5. Otherwise: all enables = 1, no flush.
- A flush output has effect only when its register's enable is 1.
- FSM states:
  - RUN:
    - If freeze: go to MEM_WAIT, wait counter = 1, stall_cnt += 1.
    - Otherwise stay in RUN.
  - MEM_WAIT:
    - Each cycle with freeze: stall_cnt += 1 and wait counter += 1 (saturating at MAX_WAIT).
    - When the wait counter reaches MAX_WAIT: timeout is set and stays set until reset. The pipeline keeps waiting; there is no abort.
    - When freeze = 0: return to RUN, clear the wait counter, and apply priorities 2-5 in that same cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- ex_rd == 0 never creates a load_use stall.
- A second load_use after a bubble cannot occur because the bubble clears ex_memread. Back-to-back load-use pairs therefore cost exactly one cycle each.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with counters and timeout cleared.

Decomposition:
- Shared package holds:
  - MIPS register index width (5).
  - State encoding: RUN = 0, MEM_WAIT = 1, as a 1-bit typedef.
  - Default CNT_W and MAX_WAIT constants.
- One natural sub-module: sat_counter (parameterised width, increment enable, async reset). It is instantiated for stall_cnt and flush_cnt, and for the wait counter.

Test Plan:
- Load-use: ex_memread = 1, ex_rd = 5, id_rs = 5, one cycle → pc_en = 0, ifid_en = 0, idex_flush = 1, stall_cnt 0→1. Next cycle with ex_memread = 0 → all enables = 1.
- No stall on $0 or unused rt: ex_memread = 1, ex_rd = 0, id_rs = 0 → no stall. Then ex_rd = 7, id_rt = 7, id_uses_rt = 0 → no stall; stall_cnt stays 0.
- Branch beats load-use: ex_branch_taken = 1 with a load_use match → ifid_flush = 1, idex_flush = 1, pc_en = 1, flush_cnt = 1, stall_cnt = 0.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles with ex_branch_taken = 1 → all enables 0 for 3 cycles, stall_cnt = 3. On the 4th cycle mem_ready = 1 → the branch flush is applied and flush_cnt = 1.
- Timeout: MAX_WAIT = 4, mem_ready held 0 for 6 cycles → timeout rises at the 4th wait cycle and stays high after mem_ready = 1. Asserting reset clears timeout, stall_cnt and flush_cnt asynchronously (checked before the next clock edge).
- Jump deferred: id_jump = 1 with load_use → first cycle is a stall (ifid_flush = 0); next cycle → ifid_flush = 1, flush_cnt = 1.
